// File: rtl/ext_host_pkg.sv
// ext_host_pkg
// Shared types and constants for the MMIO host-interface stage that sits
// between the core's external memory port and the simulation-finish module.
//   - state_t        : controller states RUN / DRAIN / FINISH / HALT
//   - *_ADDR_DEF     : default MMIO register addresses
//   - exit_bundle_t  : {finish, exitcode} bundle sent to the finish module
//   - WD_EXITCODE    : exit code reported when the watchdog fires
//   - status_word()  : packs the STATUS register read value
package ext_host_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [31:0] PUTCHAR_ADDR_DEF = 32'h4000_0000;
  localparam logic [31:0] STATUS_ADDR_DEF  = 32'h4000_0004;
  localparam logic [31:0] EXIT_ADDR_DEF    = 32'h4000_1000;

  typedef struct packed {
    logic       finish;
    logic [7:0] exitcode;
  } exit_bundle_t;

  localparam logic [7:0] WD_EXITCODE = 8'hFF;

  // STATUS layout: bit 0 exit pending, bits 8:1 FIFO fill, bit 9 watchdog fired.
  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       pending,
                                              input logic       wd_fired);
    return {22'd0, wd_fired, count, pending};
  endfunction

endpackage

// File: rtl/ext_byte_fifo.sv
// ext_byte_fifo
// Synchronous FIFO with valid/ready on both sides. Full, empty and count are
// all registers, so in_ready and out_valid never depend combinationally on
// the opposite side of the FIFO. Pointers wrap naturally (DEPTH is a power
// of two).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     write side (push on in_valid & in_ready)
//   out_valid/out_ready/out_data  read side  (pop on out_valid & out_ready)
//   count             current number of stored entries (0..DEPTH)
module ext_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  // Head entry only changes on a pop, so data is stable while stalled.
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;

  // Storage, pointers and occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10: begin
          count <= count + CW'(1);
          full  <= (count == CW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CW'(1);
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: begin
          // idle or simultaneous push/pop: occupancy unchanged
        end
      endcase
    end
  end

endmodule

// File: rtl/ext_exit_ctrl.sv
// ext_exit_ctrl
// MMIO host-interface stage between the core's external memory port and the
// simulation-finish module. Decodes writes to a putchar register (buffered
// in ext_byte_fifo and drained to the console) and to a host-exit register.
// An exit request waits until every buffered byte has left, then drives
// {finish, exitcode} for exactly one cycle and halts until reset.
// Optional feature macro: EXT_EXIT_WATCHDOG_EN (idle-timeout exit with code
// 8'hFF; STATUS bit 9 reports that it fired).
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   req_valid/req_ready           core request handshake
//   req_wr, req_addr, req_data    request type, byte address, write data
//   resp_valid, resp_data         read response, one cycle after acceptance
//   char_valid/char_ready/char_data  console byte stream
//   finish_arg                    {finish, exitcode} to the finish module
module ext_exit_ctrl
  import ext_host_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] PUTCHAR_ADDR   = PUTCHAR_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR    = STATUS_ADDR_DEF,
  parameter logic [31:0] EXIT_ADDR      = EXIT_ADDR_DEF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic [8:0]  finish_arg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        state_next;
  logic          alive;
  logic          is_put;
  logic          is_exit;
  logic          accept;
  logic          push;
  logic          exit_req;
  logic          wd_fire;
  logic          wd_status;
  logic          fifo_in_ready;
  logic [CW-1:0] fifo_count;
  logic [7:0]    exitcode;
  logic          exit_pending;
  logic [31:0]   read_value;
  exit_bundle_t  fin_next;
  logic          unused_data;

  assign is_put      = req_wr & (req_addr == PUTCHAR_ADDR);
  assign is_exit     = req_wr & (req_addr == EXIT_ADDR);
  assign unused_data = ^req_data[31:9];

  // Holds req_ready low while RST is high and until the first clock after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Request readiness: only in RUN, and a putchar stalls on the registered
  // full flag (a pop in the same cycle does not free a slot early).
  always_comb begin
    req_ready = 1'b0;
    if (alive && (state == RUN)) begin
      req_ready = ~(req_valid & is_put & ~fifo_in_ready);
    end else begin
      req_ready = 1'b0;
    end
  end

  assign accept   = req_valid & req_ready;
  assign push     = accept & is_put;
  assign exit_req = accept & is_exit & req_data[0];

`ifdef EXT_EXIT_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        wd_fired;
  logic        wd_kick;

  assign wd_kick   = accept & (is_put | is_exit);
  assign wd_fire   = (state == RUN) & ~wd_kick & (wd_cnt == (TIMEOUT_CYCLES - 32'd1));
  // A read accepted in the firing cycle already reports the watchdog bit.
  assign wd_status = wd_fired | wd_fire;

  // Idle counter: runs in RUN, cleared by console or exit writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt   <= 32'd0;
      wd_fired <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (wd_kick) begin
          wd_cnt <= 32'd0;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end
      if (wd_fire) begin
        wd_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire        = 1'b0;
  assign wd_status      = 1'b0;
`endif

  // Read decode: only STATUS is readable, everything else returns zero.
  always_comb begin
    read_value = 32'd0;
    if (req_addr == STATUS_ADDR) begin
      read_value = status_word(8'(fifo_count), exit_pending, wd_status);
    end else begin
      read_value = 32'd0;
    end
  end

  // Controller next state.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (exit_req || wd_fire) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        // char_valid mirrors the registered not-empty flag of the FIFO.
        if (!char_valid) begin
          state_next = FINISH;
        end else begin
          state_next = DRAIN;
        end
      end
      FINISH:  state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Finish bundle is registered so it is high exactly while in FINISH.
  always_comb begin
    fin_next = '0;
    if (state_next == FINISH) begin
      fin_next.finish   = 1'b1;
      fin_next.exitcode = exitcode;
    end else begin
      fin_next = '0;
    end
  end

  // Controller state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Registered responses, exit latch and finish output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid   <= 1'b0;
      resp_data    <= 32'd0;
      exitcode     <= 8'd0;
      exit_pending <= 1'b0;
      finish_arg   <= 9'd0;
    end else begin
      resp_valid <= accept & ~req_wr;
      resp_data  <= (accept & ~req_wr) ? read_value : 32'd0;
      if (exit_req) begin
        exitcode     <= req_data[8:1];
        exit_pending <= 1'b1;
      end else if (wd_fire) begin
        exitcode     <= WD_EXITCODE;
        exit_pending <= 1'b1;
      end
      finish_arg <= fin_next;
    end
  end

  ext_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (push),
    .in_ready  (fifo_in_ready),
    .in_data   (req_data[7:0]),
    .out_valid (char_valid),
    .out_ready (char_ready),
    .out_data  (char_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ext_exit_ctrl.sv
// Self-checking bench for ext_exit_ctrl: a table of register accesses, hand
// sequences for the multi-cycle corner cases and a randomized run, all
// compared cycle by cycle against a queue-based reference model.
module tb_ext_exit_ctrl;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_PUT  = 32'h4000_0000;
  localparam logic [31:0] A_STAT = 32'h4000_0004;
  localparam logic [31:0] A_EXIT = 32'h4000_1000;
  localparam int          WD_T   = 100;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [8:0]  finish_arg;

  ext_exit_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .finish_arg (finish_arg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting for the console, plus exit bookkeeping.
  logic [7:0]  mq[$];
  logic        m_exiting;
  logic        m_done;
  logic        m_pending;
  logic        m_wd_fired;
  logic [7:0]  m_code;
  int          m_wd_cnt;
  logic        m_e_rv;
  logic [31:0] m_e_rd;
  logic [8:0]  m_e_fin;

  logic [7:0]  out_log[$];
  logic [8:0]  fin_log[$];
  logic [31:0] last_resp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the model from the inputs seen before the edge; returns the
  // readiness the core should see this cycle.
  function automatic logic model_step(input logic v, input logic wr, input logic [31:0] a,
                                      input logic [31:0] d, input logic cr);
    int          qs;
    logic        put;
    logic        rdy;
    logic        acc;
    logic        fire;
    logic [31:0] st;
    qs   = mq.size();
    put  = v && wr && (a == A_PUT);
    rdy  = !m_exiting && !(put && qs == DEPTH);
    acc  = v && rdy;
    fire = 1'b0;
    m_e_fin = 9'd0;
    if (m_exiting && !m_done && qs == 0) begin
      m_e_fin = {1'b1, m_code};
      m_done  = 1'b1;
    end
`ifdef EXT_EXIT_WATCHDOG_EN
    if (!m_exiting) begin
      if (acc && wr && (a == A_PUT || a == A_EXIT)) m_wd_cnt = 0;
      else begin
        m_wd_cnt++;
        if (m_wd_cnt == WD_T) fire = 1'b1;
      end
    end
`endif
    st = {22'd0, (m_wd_fired | fire), 8'(qs), m_pending};
    m_e_rv = acc && !wr;
    m_e_rd = (acc && !wr && a == A_STAT) ? st : 32'd0;
    if (qs > 0 && cr) void'(mq.pop_front());
    if (acc && put) mq.push_back(d[7:0]);
    if (acc && wr && a == A_EXIT && d[0]) begin
      m_exiting = 1'b1;
      m_pending = 1'b1;
      m_code    = d[8:1];
    end
    if (fire) begin
      m_exiting  = 1'b1;
      m_pending  = 1'b1;
      m_code     = 8'hFF;
      m_wd_fired = 1'b1;
    end
    return rdy;
  endfunction

  // Drive one cycle, compare pre-edge handshake/console and post-edge outputs.
  task automatic drive_cycle(input logic v, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic cr,
                             output logic acc, output logic rdy_seen);
    logic       e_cv;
    logic [7:0] e_cd;
    logic       mr;
    req_valid  = v;
    req_wr     = wr;
    req_addr   = a;
    req_data   = d;
    char_ready = cr;
    #1;
    e_cv = (mq.size() > 0);
    e_cd = e_cv ? mq[0] : 8'd0;
    mr   = model_step(v, wr, a, d, cr);
    rdy_seen = req_ready;
    check("req_ready", 32'(req_ready), 32'(mr));
    check("char_valid", 32'(char_valid), 32'(e_cv));
    if (e_cv) check("char_data", 32'(char_data), 32'(e_cd));
    if (char_valid && cr) out_log.push_back(char_data);
    acc = v && mr;
    @(posedge CLK);
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_e_rv));
    check("resp_data", resp_data, m_e_rd);
    check("finish_arg", 32'(finish_arg), 32'(m_e_fin));
    if (finish_arg[8]) fin_log.push_back(finish_arg);
    last_resp = resp_data;
  endtask

  task automatic idle(input int n, input logic cr);
    logic acc;
    logic rs;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0, cr, acc, rs);
  endtask

  task automatic idle_toggle(input int n);
    logic acc;
    logic rs;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0, (i % 2) == 1, acc, rs);
  endtask

  // Hold a request until accepted, bounded.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic cr);
    logic acc;
    logic rs;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      drive_cycle(1'b1, wr, a, d, cr, acc, rs);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %h not accepted after %0d cycles, acceptance required", a, n);
    end
  endtask

  // Assert reset right now (asynchronously), check reset outputs, release.
  task automatic do_reset();
    RST        = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = 32'd0;
    req_data   = 32'd0;
    char_ready = 1'b0;
    mq.delete();
    m_exiting  = 1'b0;
    m_done     = 1'b0;
    m_pending  = 1'b0;
    m_wd_fired = 1'b0;
    m_code     = 8'd0;
    m_wd_cnt   = 0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_data", 32'(char_data), 32'd0);
    check("rst_finish_arg", 32'(finish_arg), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    m_wd_cnt = 1;  // the controller already spent this clock in RUN
    out_log.delete();
    fin_log.delete();
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vt[13];
  logic [7:0]  okn[3];
  logic        acc;
  logic        rs;
  logic [7:0]  code;
  logic [31:0] ra;
  logic [31:0] rd;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b0, A_STAT,        32'd0,     1'b1, 32'h0};
    vt[1]  = '{1'b0, 32'h4000_0008, 32'd0,     1'b1, 32'h0};
    vt[2]  = '{1'b1, A_PUT,         32'h4F,    1'b0, 32'h0};
    vt[3]  = '{1'b0, A_STAT,        32'd0,     1'b1, 32'h2};
    vt[4]  = '{1'b1, A_EXIT,        32'h0,     1'b0, 32'h0};
    vt[5]  = '{1'b0, A_STAT,        32'd0,     1'b1, 32'h2};
    vt[6]  = '{1'b1, 32'h0000_1234, 32'hFF,    1'b0, 32'h0};
    vt[7]  = '{1'b0, A_PUT,         32'd0,     1'b1, 32'h0};
    vt[8]  = '{1'b1, A_PUT,         32'h4B,    1'b0, 32'h0};
    vt[9]  = '{1'b0, A_STAT,        32'd0,     1'b1, 32'h4};
    vt[10] = '{1'b0, A_EXIT,        32'd0,     1'b1, 32'h0};
    vt[11] = '{1'b1, A_STAT,        32'h55,    1'b0, 32'h0};
    vt[12] = '{1'b0, A_STAT,        32'd0,     1'b1, 32'h4};
    okn[0] = 8'h4F;
    okn[1] = 8'h4B;
    okn[2] = 8'h0A;

    // Register map table, console stalled.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive_cycle(1'b1, vt[i].wr, vt[i].addr, vt[i].data, 1'b0, acc, rs);
      check("tbl_accept", 32'(rs), 32'd1);
      check("tbl_resp_valid", 32'(resp_valid), 32'(vt[i].exp_rv));
      check("tbl_resp_data", resp_data, vt[i].exp_rd);
    end
    idle(3, 1'b0);

    // "OK\n" then exit with PASS code.
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, A_PUT, 32'(okn[i]), 1'b1);
    send(1'b1, A_EXIT, 32'h001, 1'b1);
    idle(10, 1'b1);
    check("okn_count", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("okn_byte", 32'(out_log[i]), 32'(okn[i]));
    check("okn_fin_count", 32'(fin_log.size()), 32'd1);
    if (fin_log.size() > 0) check("okn_fin_val", 32'(fin_log[0]), 32'h100);
    drive_cycle(1'b1, 1'b0, A_STAT, 32'd0, 1'b1, acc, rs);
    check("halt_ready", 32'(rs), 32'd0);

    // Ten putchars against a stalled console.
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b1, A_PUT, 32'h30 + 32'(i), 1'b0);
    drive_cycle(1'b1, 1'b1, A_PUT, 32'h38, 1'b0, acc, rs);
    check("full_ready", 32'(rs), 32'd0);
    send(1'b0, A_STAT, 32'd0, 1'b0);
    check("full_status", last_resp, 32'h10);
    send(1'b1, A_PUT, 32'h38, 1'b1);
    send(1'b1, A_PUT, 32'h39, 1'b1);
    idle(15, 1'b1);
    check("ten_count", 32'(out_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < out_log.size(); i++) check("ten_byte", 32'(out_log[i]), 32'h30 + 32'(i));

    // Exit code 5 with a toggling console.
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, A_PUT, 32'h61 + 32'(i), 1'b0);
    send(1'b1, A_EXIT, 32'h00B, 1'b0);
    idle_toggle(20);
    check("tog_count", 32'(out_log.size()), 32'd3);
    check("tog_fin_count", 32'(fin_log.size()), 32'd1);
    if (fin_log.size() > 0) check("tog_fin_val", 32'(fin_log[0]), 32'h105);

    // Reset in the middle of draining.
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, A_PUT, 32'h70 + 32'(i), 1'b0);
    send(1'b1, A_EXIT, 32'h00B, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(20, 1'b1);
    check("mid_rst_bytes", 32'(out_log.size()), 32'd0);
    check("mid_rst_fin", 32'(fin_log.size()), 32'd0);

    // Randomized traffic against the model, then a random exit code.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = A_PUT;
        1:       ra = A_STAT;
        2:       ra = A_EXIT;
        default: ra = 32'h4000_0100 + 32'($urandom_range(0, 15) * 4);
      endcase
      rd = $urandom;
      if (ra == A_EXIT) rd[0] = 1'b0;
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, rd,
                  $urandom_range(0, 2) != 0, acc, rs);
    end
    code = 8'($urandom_range(0, 255));
    send(1'b1, A_EXIT, {23'd0, code, 1'b1}, 1'b1);
    idle(30, 1'b1);
    check("rand_fin_count", 32'(fin_log.size()), 32'd1);
    if (fin_log.size() > 0) check("rand_fin_val", 32'(fin_log[0]), {23'd0, 1'b1, code});

`ifdef EXT_EXIT_WATCHDOG_EN
    // Watchdog exit after TIMEOUT_CYCLES idle clocks.
    do_reset();
    for (int i = 0; i < 200 && m_wd_cnt < WD_T - 1; i++) idle(1, 1'b1);
    send(1'b0, A_STAT, 32'd0, 1'b1);
    check("wd_status_bit9", 32'(last_resp[9]), 32'd1);
    idle(10, 1'b1);
    check("wd_fin_count", 32'(fin_log.size()), 32'd1);
    if (fin_log.size() > 0) check("wd_fin_val", 32'(fin_log[0]), 32'h1FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
